// File: rtl/smfro_rng_ctrl.sv
// Sequencer for the 16-bit SMFRO RNG core: seed, warm up, sample, pack into words, health-test.
// Define SMFRO_VN_DEBIAS_EN to pass samples through a von Neumann debiaser before packing.
module smfro_rng_ctrl #(
    parameter int OUT_W         = 32,
    parameter int WARMUP_CYCLES = 64,
    parameter int SAMPLE_DIV    = 4,
    parameter int REP_LIMIT     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [15:0]      seed,
    input  logic [15:0]      core_state,
    output logic             core_load,
    output logic [15:0]      core_seed,
    output logic             core_run,
    output logic [OUT_W-1:0] rnd_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             busy,
    output logic             health_fail,
    output logic [2:0]       dbg_state
);

    localparam int WW = $clog2(WARMUP_CYCLES + 1);
    localparam int DW = $clog2(SAMPLE_DIV + 1);
    localparam int BW = $clog2(OUT_W);
    localparam int RW = $clog2(REP_LIMIT + 1);

    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(OUT_W - 1);
    localparam logic [RW-1:0] REP_TRIP  = RW'(REP_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEED    = 3'd1,
        S_WARMUP  = 3'd2,
        S_COLLECT = 3'd3,
        S_LOAD    = 3'd4,
        S_HOLD    = 3'd5,
        S_FAIL    = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [WW-1:0]    warm_q, warm_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [15:0]      seed_q, seed_d;
    logic             hfail_q, hfail_d;
    logic [15:0]      prev_q, prev_d;
    logic [RW-1:0]    rep_q, rep_d;

    logic             sample;
    logic             new_bit;
    logic [RW-1:0]    rep_next;
    logic             trip;
    logic             emit;
    logic             emit_bit;
    logic             word_done;

    // Handshake: a word transfers on any edge where rnd_valid && rnd_ready; rnd_data
    // is stable while rnd_valid is high and rnd_valid never drops without a transfer
    // except when en falls.

    assign sample   = (state_q == S_COLLECT) && (div_q == DIV_LAST);
    assign new_bit  = ^core_state;
    // rep_q == 0 marks "no previous sample yet" after seeding.
    assign rep_next = ((rep_q != '0) && (core_state == prev_q)) ? rep_q + RW'(1) : RW'(1);
    assign trip     = sample && ((core_state == 16'h0000) || (rep_next == REP_TRIP));

`ifdef SMFRO_VN_DEBIAS_EN
    logic pair_q, pair_d;
    logic b0_q, b0_d;

    // Pair (b0,b1): 01 emits 0, 10 emits 1, so the emitted bit is always b0.
    assign emit     = sample && pair_q && (b0_q != new_bit);
    assign emit_bit = b0_q;
`else
    assign emit     = sample;
    assign emit_bit = new_bit;
`endif

    assign word_done = emit && (bit_q == BIT_LAST);

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        div_d   = div_q;
        bit_d   = bit_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = valid_q;
        seed_d  = seed_q;
        hfail_d = hfail_q;
        prev_d  = prev_q;
        rep_d   = rep_q;
`ifdef SMFRO_VN_DEBIAS_EN
        pair_d  = pair_q;
        b0_d    = b0_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_SEED;
                    // The all-zero state is a fixed point of the core, so never seed it.
                    seed_d  = (seed == 16'h0000) ? 16'h0001 : seed;
                    hfail_d = 1'b0;
                    warm_d  = '0;
                    div_d   = '0;
                    bit_d   = '0;
                    acc_d   = '0;
                    prev_d  = '0;
                    rep_d   = '0;
`ifdef SMFRO_VN_DEBIAS_EN
                    pair_d  = 1'b0;
                    b0_d    = 1'b0;
`endif
                end
            end
            S_SEED: begin
                state_d = S_WARMUP;
                warm_d  = '0;
            end
            S_WARMUP: begin
                if (warm_q == WARM_LAST) begin
                    state_d = S_COLLECT;
                    div_d   = '0;
                end else begin
                    warm_d = warm_q + WW'(1);
                end
            end
            S_COLLECT: begin
                div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
                if (sample) begin
                    prev_d = core_state;
                    rep_d  = rep_next;
                    if (trip) begin
                        state_d = S_FAIL;
                        hfail_d = 1'b1;
                        acc_d   = '0;
                        bit_d   = '0;
`ifdef SMFRO_VN_DEBIAS_EN
                        pair_d  = 1'b0;
`endif
                    end else begin
`ifdef SMFRO_VN_DEBIAS_EN
                        pair_d = ~pair_q;
                        if (!pair_q) begin
                            b0_d = new_bit;
                        end
`endif
                        if (emit) begin
                            acc_d = {emit_bit, acc_q[OUT_W-1:1]};
                            bit_d = word_done ? '0 : bit_q + BW'(1);
                        end
                        if (word_done) begin
                            state_d = S_LOAD;
                        end
                    end
                end
            end
            S_LOAD: begin
                data_d  = acc_q;
                valid_d = 1'b1;
                acc_d   = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (valid_q && rnd_ready) begin
                    valid_d = 1'b0;
                    div_d   = '0;
                    state_d = S_COLLECT;
                end
            end
            S_FAIL: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Dropping en wins over everything else; rnd_data and health_fail are kept.
        if (!en) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            warm_d  = '0;
            div_d   = '0;
            bit_d   = '0;
            acc_d   = '0;
            prev_d  = '0;
            rep_d   = '0;
            hfail_d = hfail_q;
`ifdef SMFRO_VN_DEBIAS_EN
            pair_d  = 1'b0;
            b0_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            warm_q  <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            seed_q  <= '0;
            hfail_q <= 1'b0;
            prev_q  <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            seed_q  <= seed_d;
            hfail_q <= hfail_d;
            prev_q  <= prev_d;
            rep_q   <= rep_d;
        end
    end

`ifdef SMFRO_VN_DEBIAS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q <= 1'b0;
            b0_q   <= 1'b0;
        end else begin
            pair_q <= pair_d;
            b0_q   <= b0_d;
        end
    end
`endif

    assign core_load   = (state_q == S_SEED);
    assign core_run    = (state_q == S_SEED) || (state_q == S_WARMUP) || (state_q == S_COLLECT) ||
                         (state_q == S_LOAD) || (state_q == S_HOLD);
    assign core_seed   = seed_q;
    assign rnd_data    = data_q;
    assign rnd_valid   = valid_q;
    assign busy        = (state_q != S_IDLE);
    assign health_fail = hfail_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_smfro_rng_ctrl.sv
// Bench for smfro_rng_ctrl: directed scenarios plus randomized runs against a sample-level model
// (parity packing, repetition/zero health rules, fixed seed/warm-up/sample timeline).
module tb_smfro_rng_ctrl;

    localparam int OUT_W         = 8;
    localparam int WARMUP_CYCLES = 4;
    localparam int SAMPLE_DIV    = 2;
    localparam int REP_LIMIT     = 3;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [15:0]      seed;
    logic [15:0]      core_state;
    logic             core_load;
    logic [15:0]      core_seed;
    logic             core_run;
    logic [OUT_W-1:0] rnd_data;
    logic             rnd_valid;
    logic             rnd_ready;
    logic             busy;
    logic             health_fail;
    logic [2:0]       dbg_state;

    always #5 clk = ~clk;

    smfro_rng_ctrl #(
        .OUT_W(OUT_W),
        .WARMUP_CYCLES(WARMUP_CYCLES),
        .SAMPLE_DIV(SAMPLE_DIV),
        .REP_LIMIT(REP_LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .seed(seed),
        .core_state(core_state),
        .core_load(core_load),
        .core_seed(core_seed),
        .core_run(core_run),
        .rnd_data(rnd_data),
        .rnd_valid(rnd_valid),
        .rnd_ready(rnd_ready),
        .busy(busy),
        .health_fail(health_fail),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    int               n_checks = 0;
    int               n_errors = 0;
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] last_word = '0;
    logic [15:0]      prev_s;
    int               rep_s;
    bit               have_prev;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // All driving and sampling happens at negedges; the DUT acts on posedges.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] distinct_val(input bit p, input logic [15:0] prev);
        logic [15:0] v;
        v = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            v = 16'($urandom_range(1, 65535));
            if ((^v) != p) v = v ^ 16'h0100;
            if (v == 16'h0000) v = 16'h0003;
            if (v != prev) break;
        end
        return v;
    endfunction

    function automatic logic [15:0] pick(input logic [15:0] prev);
        int r;
        r = $urandom_range(0, 31);
        if (r < 6) return prev;
        if (r == 6) return 16'h0000;
        return 16'($urandom_range(1, 65535));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_run(input logic [15:0] s);
        logic [15:0] exp_seed;
        exp_seed   = (s == 16'h0000) ? 16'h0001 : s;
        seed       = s;
        en         = 1'b1;
        core_state = 16'($urandom);
        tick();
        check("seed_core_load", core_load, 1);
        check("seed_core_seed", core_seed, exp_seed);
        check("seed_core_run", core_run, 1);
        check("seed_health_clear", health_fail, 0);
        check("seed_busy", busy, 1);
        have_prev = 0;
        rep_s     = 0;
        seed      = 16'($urandom);
        for (int i = 0; i < WARMUP_CYCLES + 1; i++) begin
            core_state = 16'($urandom);
            tick();
            if (i == 0) begin
                check("warm_core_load", core_load, 0);
                check("warm_core_seed_held", core_seed, exp_seed);
                check("warm_core_run", core_run, 1);
            end
        end
    endtask

    task automatic sample_one(input logic [15:0] v, output bit tripped);
        logic [15:0] decoy;
        decoy = v ^ 16'h0001;
        if (decoy == 16'h0000) decoy = 16'h0003;
        for (int i = 0; i < SAMPLE_DIV - 1; i++) begin
            core_state = decoy;
            tick();
        end
        core_state = v;
        tick();
        if (have_prev && (v == prev_s)) rep_s++;
        else rep_s = 1;
        prev_s    = v;
        have_prev = 1;
        tripped   = (v == 16'h0000) || (rep_s >= REP_LIMIT);
        check("health_fail", health_fail, tripped);
        check("core_run", core_run, !tripped);
        if (tripped) check("valid_on_fail", rnd_valid, 0);
    endtask

    task automatic collect_word(input logic [15:0] vals[OUT_W], output bit failed);
        logic [OUT_W-1:0] word;
        logic [OUT_W-1:0] exp;
        bit               t;
        failed = 0;
        word   = '0;
        for (int j = 0; j < OUT_W; j++) begin
            sample_one(vals[j], t);
            word[j] = ^vals[j];
            if (t) begin
                failed = 1;
                break;
            end
        end
        if (!failed) begin
            exp_q.push_back(word);
            check("valid_before_load", rnd_valid, 0);
            core_state = 16'($urandom);
            tick();
            exp = exp_q.pop_front();
            check("valid_word", rnd_valid, 1);
            check("rnd_data", rnd_data, exp);
            last_word = exp;
        end
    endtask

    task automatic hold_and_accept(input int n);
        for (int i = 0; i < n; i++) begin
            core_state = 16'($urandom);
            check("hold_valid", rnd_valid, 1);
            check("hold_data_stable", rnd_data, last_word);
            tick();
        end
        rnd_ready = 1'b1;
        check("hold_valid_at_ack", rnd_valid, 1);
        tick();
        rnd_ready = 1'b0;
        check("valid_after_ack", rnd_valid, 0);
        check("busy_after_ack", busy, 1);
    endtask

    task automatic stop_run();
        en = 1'b0;
        tick();
        check("stop_busy", busy, 0);
        check("stop_valid", rnd_valid, 0);
        check("stop_core_run", core_run, 0);
        check("stop_data_kept", rnd_data, last_word);
    endtask

    task automatic check_fail_state(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("fail_sticky", health_fail, 1);
            check("fail_core_run", core_run, 0);
            check("fail_valid", rnd_valid, 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] vals[OUT_W];
        logic [15:0] prev;
        bit          failed;
        bit          t;
        int          first_load;
        int          n_load;
        bit          par[OUT_W];

        rst_n      = 1'b1;
        en         = 1'b1;
        seed       = 16'h1234;
        core_state = 16'h0000;
        rnd_ready  = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);

        // Reset held with en=1: every output stays 0.
        for (int i = 0; i < 3; i++) begin
            check("reset_outputs", {core_load, core_seed, core_run, rnd_data, rnd_valid, busy, health_fail}, 0);
            tick();
        end
        rst_n      = 1'b1;
        first_load = 0;
        n_load     = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (core_load) begin
                n_load++;
                if (first_load == 0) first_load = c;
            end
        end
        check("load_first_cycle", first_load, 1);
        check("load_pulse_count", n_load, 1);
        en = 1'b0;
        tick();
        check("idle_after_en_low", busy, 0);

        // Zero seed forced to 1, then the 1,0,1,1,0,0,1,0 parity word.
        start_run(16'h0000);
        par  = '{1, 0, 1, 1, 0, 0, 1, 0};
        prev = 16'h0000;
        for (int j = 0; j < OUT_W; j++) begin
            vals[j] = distinct_val(par[j], prev);
            prev    = vals[j];
        end
        collect_word(vals, failed);
        check("word_4d", rnd_data, 8'h4D);

        // Consumer stalls for 10 cycles, then accepts; sampling resumes.
        hold_and_accept(10);
        for (int j = 0; j < OUT_W; j++) begin
            vals[j] = distinct_val(1'($urandom_range(0, 1)), prev);
            prev    = vals[j];
        end
        collect_word(vals, failed);
        hold_and_accept(1);
        stop_run();

        // Stuck core state trips the repetition test on the 3rd identical sample.
        start_run(16'($urandom_range(1, 65535)));
        for (int j = 0; j < OUT_W; j++) vals[j] = 16'hA5A5;
        collect_word(vals, failed);
        check_fail_state(3);
        stop_run();
        check("fail_kept_in_idle", health_fail, 1);

        // en dropped on the 5th sample of a word, then a clean new word.
        start_run(16'($urandom_range(1, 65535)));
        prev = 16'h0000;
        for (int j = 0; j < 4; j++) begin
            vals[j] = distinct_val(1'($urandom_range(0, 1)), prev);
            prev    = vals[j];
            sample_one(vals[j], t);
        end
        core_state = 16'h1111;
        tick();
        core_state = 16'h1113;
        en         = 1'b0;
        tick();
        check("drop_valid", rnd_valid, 0);
        check("drop_busy", busy, 0);
        check("drop_core_run", core_run, 0);
        check("drop_data_kept", rnd_data, last_word);
        start_run(16'($urandom_range(1, 65535)));
        for (int j = 0; j < OUT_W; j++) begin
            vals[j] = distinct_val(1'($urandom_range(0, 1)), prev);
            prev    = vals[j];
        end
        collect_word(vals, failed);
        hold_and_accept(2);
        stop_run();

        // Randomized runs with repeats and zero samples mixed in.
        for (int run = 0; run < 10; run++) begin
            start_run(($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom));
            prev = 16'h5555;
            for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
                for (int j = 0; j < OUT_W; j++) begin
                    vals[j] = pick(prev);
                    prev    = vals[j];
                end
                collect_word(vals, failed);
                if (failed) begin
                    check_fail_state(2);
                    break;
                end
                hold_and_accept(int'($urandom_range(0, 4)));
            end
            stop_run();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
